// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the OV7670 configuration sequencer:
// FSM state encoding, table marker codes and table geometry.
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_DECODE = 3'd2,
    ST_SEND   = 3'd3,
    ST_DELAY  = 3'd4,
    ST_TAIL   = 3'd5,
    ST_DONE   = 3'd6
  } cfg_state_e;

  localparam logic [15:0] CFG_DELAY = 16'hFFF0;
  localparam logic [15:0] CFG_END   = 16'hFFFF;

  localparam int CFG_DEPTH = 256;
  localparam int CFG_AW    = 8;
  localparam int CFG_CNT_W = 20;

  localparam logic [CFG_AW-1:0] CFG_LAST = 8'd255;

  // The last slot always terminates the walk, so the index never has to wrap.
  function automatic logic cfg_is_end(input logic [15:0] entry, input logic [CFG_AW-1:0] addr);
    return (entry == CFG_END) || (addr == CFG_LAST);
  endfunction

endpackage

// File: rtl/cam_config_rom.sv
// 256x16 synchronous-read register table for the OV7670 ({register, value}).
// TABLE_SEL picks the production table (0) or short bring-up tables (1, 2).
module cam_config_rom
  import cam_cfg_pkg::*;
#(
  parameter int TABLE_SEL = 0
) (
  input  logic              clk_i,
  input  logic [CFG_AW-1:0] addr_i,
  output logic [15:0]       data_o
);

  function automatic logic [15:0] ov7670_entry(input logic [CFG_AW-1:0] a);
    logic [15:0] e;
    case (a)
      8'd0:    e = 16'h1280;
      8'd1:    e = CFG_DELAY;
      8'd2:    e = 16'h1204;
      8'd3:    e = 16'h1100;
      8'd4:    e = 16'h0C00;
      8'd5:    e = 16'h3E00;
      8'd6:    e = 16'h8C00;
      8'd7:    e = 16'h0400;
      8'd8:    e = 16'h40D0;
      8'd9:    e = 16'h3A04;
      8'd10:   e = 16'h1418;
      8'd11:   e = 16'h4FB3;
      8'd12:   e = 16'h50B3;
      8'd13:   e = 16'h5100;
      8'd14:   e = 16'h523D;
      8'd15:   e = 16'h53A7;
      8'd16:   e = 16'h54E4;
      8'd17:   e = 16'h589E;
      8'd18:   e = 16'h3DC0;
      8'd19:   e = 16'h1714;
      8'd20:   e = 16'h1802;
      8'd21:   e = 16'h3280;
      8'd22:   e = 16'h1903;
      8'd23:   e = 16'h1A7B;
      8'd24:   e = 16'h030A;
      8'd25:   e = 16'h0E61;
      8'd26:   e = 16'h0F4B;
      8'd27:   e = 16'h1602;
      8'd28:   e = 16'h1E37;
      8'd29:   e = 16'h2102;
      8'd30:   e = 16'h2291;
      8'd31:   e = 16'h2907;
      8'd32:   e = 16'h330B;
      8'd33:   e = 16'h350B;
      8'd34:   e = 16'h371D;
      8'd35:   e = 16'h3871;
      8'd36:   e = 16'h392A;
      8'd37:   e = 16'h3C78;
      8'd38:   e = 16'h4D40;
      8'd39:   e = 16'h4E20;
      8'd40:   e = 16'h6900;
      8'd41:   e = 16'h6B4A;
      8'd42:   e = 16'h7410;
      8'd43:   e = 16'h8D4F;
      8'd44:   e = 16'h8E00;
      8'd45:   e = 16'h8F00;
      8'd46:   e = 16'h9000;
      8'd47:   e = 16'h9100;
      8'd48:   e = 16'h9600;
      8'd49:   e = 16'h9A00;
      8'd50:   e = 16'hB084;
      8'd51:   e = 16'hB10C;
      8'd52:   e = 16'hB20E;
      8'd53:   e = 16'hB382;
      8'd54:   e = 16'hB80A;
      8'd55:   e = CFG_END;
      default: e = CFG_END;
    endcase
    return e;
  endfunction

  function automatic logic [15:0] short_entry(input logic [CFG_AW-1:0] a);
    logic [15:0] e;
    case (a)
      8'd0:    e = 16'h1280;
      8'd1:    e = CFG_DELAY;
      8'd2:    e = 16'h1204;
      8'd3:    e = 16'h40D0;
      8'd4:    e = 16'h3A04;
      8'd5:    e = CFG_END;
      default: e = CFG_END;
    endcase
    return e;
  endfunction

  // Table with no end marker: relies on the forced stop at the last slot.
  function automatic logic [15:0] sweep_entry(input logic [CFG_AW-1:0] a);
    logic [15:0] e;
    case (a)
      8'd0:    e = 16'h1280;
      8'd1:    e = CFG_DELAY;
      default: e = {a, ~a};
    endcase
    return e;
  endfunction

  function automatic logic [15:0] lookup(input logic [CFG_AW-1:0] a);
    logic [15:0] e;
    case (TABLE_SEL)
      1:       e = short_entry(a);
      2:       e = sweep_entry(a);
      default: e = ov7670_entry(a);
    endcase
    return e;
  endfunction

  // One-cycle synchronous read; consumer takes data_o unregistered.
  always_ff @(posedge clk_i) begin
    data_o <= lookup(addr_i);
  end

endmodule

// File: rtl/cam_config_sequencer.sv
// Walks the camera register table and hands one write at a time to the SCCB
// engine, honouring delay/end markers and a bus-drain tail before done.
module cam_config_sequencer
  import cam_cfg_pkg::*;
#(
  parameter logic [7:0] SCCB_ID      = 8'h42,
  parameter int         DELAY_CYCLES = 500000,
  parameter int         TAIL_CYCLES  = 8192,
  parameter int         TABLE_SEL    = 0
) (
  input  logic       clk_50Mhz,
  input  logic       rst,
  input  logic       start,
  input  logic       i2c_taken,
  output logic       i2c_send,
  output logic [7:0] i2c_id,
  output logic [7:0] i2c_register,
  output logic [7:0] i2c_value,
  output logic       busy,
  output logic       done,
  output logic [7:0] index
);

  localparam logic [CFG_CNT_W-1:0] DELAY_LOAD = CFG_CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CFG_CNT_W-1:0] TAIL_LOAD  = CFG_CNT_W'(TAIL_CYCLES - 1);
  localparam logic [CFG_CNT_W-1:0] CNT_ZERO   = 20'd0;
  localparam logic [CFG_CNT_W-1:0] CNT_ONE    = 20'd1;

  cfg_state_e           state_q;
  logic [CFG_AW-1:0]    index_q;
  logic [CFG_AW-1:0]    index_d;
  logic [7:0]           reg_q;
  logic [7:0]           val_q;
  logic                 send_q;
  logic [CFG_CNT_W-1:0] cnt_q;
  logic [15:0]          rom_data;

  cam_config_rom #(
    .TABLE_SEL(TABLE_SEL)
  ) u_rom (
    .clk_i (clk_50Mhz),
    .addr_i(index_q),
    .data_o(rom_data)
  );

  // Saturating table-pointer increment.
  always_comb begin
    if (index_q == CFG_LAST) begin
      index_d = CFG_LAST;
    end else begin
      index_d = index_q + 8'd1;
    end
  end

  // Sequencer FSM with registered write request and payload.
  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      index_q <= 8'd0;
      reg_q   <= 8'd0;
      val_q   <= 8'd0;
      send_q  <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            index_q <= 8'd0;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          if (cfg_is_end(rom_data, index_q)) begin
            cnt_q   <= TAIL_LOAD;
            state_q <= ST_TAIL;
          end else if (rom_data == CFG_DELAY) begin
            cnt_q   <= DELAY_LOAD;
            state_q <= ST_DELAY;
          end else begin
            reg_q   <= rom_data[15:8];
            val_q   <= rom_data[7:0];
            send_q  <= 1'b1;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i2c_taken) begin
            send_q  <= 1'b0;
            index_q <= index_d;
            state_q <= ST_READ;
          end
        end
        ST_DELAY: begin
          if (cnt_q == CNT_ZERO) begin
            index_q <= index_d;
            state_q <= ST_READ;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_TAIL: begin
          if (cnt_q == CNT_ZERO) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          send_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign i2c_send     = send_q;
  assign i2c_id       = SCCB_ID;
  assign i2c_register = reg_q;
  assign i2c_value    = val_q;
  assign index        = index_q;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_cam_config_sequencer.sv
// Scoreboard bench: instance 0 runs a short table (end at entry 5), instance 1
// a table without end marker; random spurious start/taken pulses while busy.
module tb_cam_config_sequencer;

  localparam int D = 16;
  localparam int T = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] start_m = 2'b00;
  logic [1:0] start_n = 2'b00;
  logic [1:0] taken_n = 2'b00;
  logic [1:0] taken_w;
  logic [1:0] send_v, busy_v, done_v;
  logic [7:0] id_v  [2];
  logic [7:0] reg_v [2];
  logic [7:0] val_v [2];
  logic [7:0] idx_v [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         inst;
    int         cyc;
    int         entry;
    logic [7:0] r;
    logic [7:0] v;
  } exp_t;

  exp_t expq[$];
  int   exp_done [2] = '{-1, -1};
  int   ncmp = 0;
  int   nfail = 0;
  bit   noise_en = 1'b0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic taken_r = 1'b0;
    assign taken_w[g] = taken_r | taken_n[g];

    cam_config_sequencer #(
      .SCCB_ID     (8'h42),
      .DELAY_CYCLES(D),
      .TAIL_CYCLES (T),
      .TABLE_SEL   (g + 1)
    ) u_dut (
      .clk_50Mhz   (clk),
      .rst         (rst),
      .start       (start_m[g] | start_n[g]),
      .i2c_taken   (taken_w[g]),
      .i2c_send    (send_v[g]),
      .i2c_id      (id_v[g]),
      .i2c_register(reg_v[g]),
      .i2c_value   (val_v[g]),
      .busy        (busy_v[g]),
      .done        (done_v[g]),
      .index       (idx_v[g])
    );

    // I2C engine stand-in: accept pulse 5 cycles after each request rises.
    initial forever begin
      @(posedge send_v[g]);
      repeat (5) @(posedge clk);
      #1 taken_r = 1'b1;
      @(posedge clk);
      #1 taken_r = 1'b0;
    end
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s[%0d]: got %0h expected %0h at cycle %0d", nm, inst, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] tbl(input int sel, input int i);
    logic [7:0] a;
    a = i[7:0];
    if (i == 0) return 16'h1280;
    if (i == 1) return 16'hFFF0;
    if (sel == 1) begin
      case (i)
        2:       return 16'h1204;
        3:       return 16'h40D0;
        4:       return 16'h3A04;
        default: return 16'hFFFF;
      endcase
    end
    return {a, ~a};
  endfunction

  // Expected writes and done time, given the edge at which start is sampled.
  task automatic run_model(input int inst, input int k);
    int t;
    logic [15:0] e;
    t = k;
    for (int idx = 0; idx < 256; idx++) begin
      e = tbl(inst + 1, idx);
      if (e == 16'hFFFF || idx == 255) begin
        exp_done[inst] = t + 2 + T;
        break;
      end else if (e == 16'hFFF0) begin
        t = t + 2 + D;
      end else begin
        expq.push_back('{inst, t + 2, idx, e[15:8], e[7:0]});
        t = t + 8;
      end
    end
  endtask

  function automatic int find(input int i);
    foreach (expq[j]) if (expq[j].inst == i) return j;
    return -1;
  endfunction

  function automatic int pending(input int i);
    int n = 0;
    foreach (expq[j]) if (expq[j].inst == i) n++;
    return n;
  endfunction

  // Monitor: pops the scoreboard on each request and checks hold/done timing.
  logic [1:0] prev_send = 2'b00;
  logic [1:0] prev_done = 2'b00;
  logic [7:0] cur_r [2];
  logic [7:0] cur_v [2];
  int         cur_e [2];
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        if (send_v[i] && !prev_send[i]) begin
          int k;
          k = find(i);
          if (k < 0) begin
            chk("unexpected_send", i, {24'd0, idx_v[i]}, 32'hFFFF_FFFF);
          end else begin
            chk("send_cycle", i, cyc, expq[k].cyc);
            chk("send_reg", i, reg_v[i], expq[k].r);
            chk("send_val", i, val_v[i], expq[k].v);
            chk("send_id", i, id_v[i], 8'h42);
            chk("index_at_send", i, idx_v[i], expq[k].entry);
            cur_r[i] = expq[k].r;
            cur_v[i] = expq[k].v;
            cur_e[i] = expq[k].entry;
            expq.delete(k);
          end
        end else if (send_v[i]) begin
          chk("hold_reg", i, reg_v[i], cur_r[i]);
          chk("hold_val", i, val_v[i], cur_v[i]);
        end else if (prev_send[i]) begin
          chk("index_after_taken", i, idx_v[i], cur_e[i] + 1);
        end
        if (done_v[i] && !prev_done[i]) begin
          chk("done_cycle", i, cyc, exp_done[i]);
          exp_done[i] = -1;
        end
      end
      prev_send[i] = send_v[i];
      prev_done[i] = done_v[i];
    end
  end

  // Spurious start/taken pulses only where they must be ignored.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      start_n[i] = noise_en && busy_v[i] && ($urandom_range(0, 3) == 0);
      taken_n[i] = noise_en && busy_v[i] && !send_v[i] && ($urandom_range(0, 3) == 0);
    end
  end

  task automatic check_reset_vals();
    for (int i = 0; i < 2; i++) begin
      chk("rst_send", i, send_v[i], 1'b0);
      chk("rst_busy", i, busy_v[i], 1'b0);
      chk("rst_done", i, done_v[i], 1'b0);
      chk("rst_index", i, idx_v[i], 8'd0);
      chk("rst_reg", i, reg_v[i], 8'd0);
      chk("rst_val", i, val_v[i], 8'd0);
      chk("rst_id", i, id_v[i], 8'h42);
    end
  endtask

  task automatic do_start(input int i);
    repeat ($urandom_range(1, 6)) @(posedge clk);
    #1;
    chk("busy_before_start", i, busy_v[i], 1'b0);
    run_model(i, cyc + 1);
    start_m[i] = 1'b1;
    @(posedge clk);
    #1 start_m[i] = 1'b0;
    chk("busy_after_start", i, busy_v[i], 1'b1);
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (!done_v[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", i, done_v[i], 1'b1);
    if (done_v[i]) begin
      chk("busy_in_done", i, busy_v[i], 1'b0);
      chk("leftover_writes", i, pending(i), 0);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    rst = 1'b0;
    noise_en = 1'b1;

    do_start(0);
    wait_done(0, 300);
    do_start(0);
    wait_done(0, 300);

    do_start(0);
    n = 0;
    while (!send_v[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_before_reset", 0, send_v[0], 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals();
    for (int j = expq.size() - 1; j >= 0; j--) if (expq[j].inst == 0) expq.delete(j);
    exp_done[0] = -1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("idle_after_reset", 0, {busy_v[0], done_v[0]}, 2'b00);

    do_start(0);
    wait_done(0, 300);

    do_start(1);
    wait_done(1, 4000);
    chk("saturated_index", 1, idx_v[1], 8'd255);

    noise_en = 1'b0;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
